cell_grid_renderer: RTL and testbench



---
 rtl/vga_pkg.sv | 21 ++
 rtl/cell_grid_renderer_if.sv | 10 +
 rtl/grid_position_counter.sv | 80 ++++++++
 rtl/cell_grid_renderer.sv | 116 +++++++++++
 tb/tb_cell_grid_renderer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants, types and pipeline attribute struct for the
// Game-of-Life cell grid renderer.
package vga_pkg;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 20;
  localparam int CELL_W    = H_ACTIVE / GRID_COLS;
  localparam int CELL_H    = V_ACTIVE / GRID_ROWS;

  typedef logic [11:0] rgb12_t;
  typedef logic [8:0]  cell_addr_t;

  typedef enum logic {UNSYNCED = 1'b0, SYNCED = 1'b1} sync_state_t;

  typedef struct packed {
    logic vis;
    logic in_grid;
    logic border;
  } pix_attr_t;
endpackage

// File: rtl/cell_grid_renderer_if.sv
// Cell buffer read port: address/strobe out of the renderer, 1-cycle-latency data back.
interface cell_grid_renderer_if;
  import vga_pkg::*;
  logic       cell_rd_en;
  cell_addr_t cell_addr;
  logic       cell_data;

  modport master (output cell_rd_en, output cell_addr, input cell_data);
  modport slave  (input cell_rd_en, input cell_addr, output cell_data);
endinterface

// File: rtl/grid_position_counter.sv
// Beam position tracker: pixel/cell counters driven only by the blanking strobes,
// producing the cell address and per-pixel grid attributes for the current cycle.
module grid_position_counter
  import vga_pkg::*;
#(
  parameter int COLS    = GRID_COLS,
  parameter int ROWS    = GRID_ROWS,
  parameter int CW      = CELL_W,
  parameter int CH      = CELL_H,
  parameter bit GRID_EN = 1'b1
) (
  input  logic       pixel_clock,
  input  logic       rst_n,
  input  logic       i_hblank_n,
  input  logic       i_vblank_n,
  output cell_addr_t o_cell_addr,
  output logic       o_border,
  output logic       o_in_grid
);
  localparam int PXW = $clog2(CW + 1);
  localparam int CLW = $clog2(COLS + 1);
  localparam int LNW = $clog2(CH + 1);
  localparam int RWW = $clog2(ROWS + 1);

  logic [PXW-1:0] r_px;
  logic [CLW-1:0] r_col;
  logic [LNW-1:0] r_ln;
  logic [RWW-1:0] r_row;
  cell_addr_t     r_row_base;
  logic           r_hblank_n_d;
  logic           w_blank_n, w_line_end, w_col_ok, w_row_ok;

  assign w_blank_n  = i_hblank_n & i_vblank_n;
  // End of a visible line: hblank falls while the frame is still active.
  assign w_line_end = r_hblank_n_d & ~i_hblank_n & i_vblank_n;
  assign w_col_ok   = (r_col < CLW'(COLS));
  assign w_row_ok   = (r_row < RWW'(ROWS));

  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_hblank_n_d <= 1'b0;
      r_px         <= '0;
      r_col        <= '0;
      r_ln         <= '0;
      r_row        <= '0;
      r_row_base   <= '0;
    end else begin
      r_hblank_n_d <= i_hblank_n;
      if (!i_hblank_n) begin
        r_px  <= '0;
        r_col <= '0;
      end else if (w_blank_n && w_col_ok) begin
        if (r_px == PXW'(CW - 1)) begin
          r_px  <= '0;
          r_col <= r_col + 1'b1;
        end else begin
          r_px <= r_px + 1'b1;
        end
      end
      // Vertical clear takes priority over a coincident line end.
      if (!i_vblank_n) begin
        r_ln       <= '0;
        r_row      <= '0;
        r_row_base <= '0;
      end else if (w_line_end && w_row_ok) begin
        if (r_ln == LNW'(CH - 1)) begin
          r_ln       <= '0;
          r_row      <= r_row + 1'b1;
          r_row_base <= r_row_base + cell_addr_t'(COLS);
        end else begin
          r_ln <= r_ln + 1'b1;
        end
      end
    end
  end

  assign o_cell_addr = r_row_base + cell_addr_t'(r_col);
  assign o_border    = GRID_EN && ((r_px == '0) || (r_ln == '0));
  assign o_in_grid   = w_col_ok & w_row_ok;
endmodule

// File: rtl/cell_grid_renderer.sv
// Three-stage pixel pipeline: cell fetch, attribute alignment, colour select,
// with sync outputs delayed to match and an end-of-frame pulse for the updater.
module cell_grid_renderer
  import vga_pkg::*;
#(
  parameter int     COLS      = GRID_COLS,
  parameter int     ROWS      = GRID_ROWS,
  parameter int     CW        = CELL_W,
  parameter int     CH        = CELL_H,
  parameter bit     GRID_EN   = 1'b1,
  parameter rgb12_t ALIVE_RGB = 12'hFFF,
  parameter rgb12_t DEAD_RGB  = 12'h000,
  parameter rgb12_t GRID_RGB  = 12'h444
) (
  input  logic                        pixel_clock,
  input  logic                        rst_n,
  input  logic                        hblank_n,
  input  logic                        vblank_n,
  input  logic                        hsync_n_in,
  input  logic                        vsync_n_in,
  cell_grid_renderer_if.master        cbuf,
  output logic [3:0]                  vga_r,
  output logic [3:0]                  vga_g,
  output logic [3:0]                  vga_b,
  output logic                        vga_hs,
  output logic                        vga_vs,
  output logic                        frame_done
);
  localparam int STAGES = 3;

  sync_state_t       r_state, w_state_nxt;
  logic              w_synced, w_frame_end;
  logic              w_blank_n, w_border, w_in_grid;
  cell_addr_t        w_cell_addr;
  logic              r_vblank_n_d;
  logic              r_cell_rd_en;
  cell_addr_t        r_cell_addr;
  logic              r_frame_done;
  pix_attr_t         r_attr_s0, r_attr_s1;
  logic [STAGES-1:0] r_hs_pipe, r_vs_pipe;
  rgb12_t            r_rgb, w_rgb;

  assign w_blank_n = hblank_n & vblank_n;

  grid_position_counter #(
    .COLS(COLS), .ROWS(ROWS), .CW(CW), .CH(CH), .GRID_EN(GRID_EN)
  ) u_pos (
    .pixel_clock (pixel_clock),
    .rst_n       (rst_n),
    .i_hblank_n  (hblank_n),
    .i_vblank_n  (vblank_n),
    .o_cell_addr (w_cell_addr),
    .o_border    (w_border),
    .o_in_grid   (w_in_grid)
  );

  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) r_state <= UNSYNCED;
    else        r_state <= w_state_nxt;
  end

  // Counters are only trustworthy after a vertical blank has cleared them.
  always_comb begin
    w_state_nxt = r_state;
    w_synced    = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      UNSYNCED: if (!vblank_n) w_state_nxt = SYNCED;
      SYNCED: begin
        w_synced    = 1'b1;
        w_frame_end = r_vblank_n_d & ~vblank_n;
      end
      default: w_state_nxt = UNSYNCED;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_vblank_n_d <= 1'b0;
      r_cell_rd_en <= 1'b0;
      r_cell_addr  <= '0;
      r_frame_done <= 1'b0;
      r_attr_s0    <= '0;
      r_attr_s1    <= '0;
      r_rgb        <= '0;
      r_hs_pipe    <= '1;
      r_vs_pipe    <= '1;
    end else begin
      r_vblank_n_d <= vblank_n;
      r_cell_rd_en <= w_blank_n & w_in_grid;
      r_cell_addr  <= w_cell_addr;
      r_frame_done <= w_frame_end;
      r_attr_s0    <= '{vis: w_blank_n & w_synced, in_grid: w_in_grid, border: w_border};
      r_attr_s1    <= r_attr_s0;
      r_rgb        <= w_rgb;
      r_hs_pipe    <= {r_hs_pipe[STAGES-2:0], hsync_n_in};
      r_vs_pipe    <= {r_vs_pipe[STAGES-2:0], vsync_n_in};
    end
  end

  always_comb begin
    w_rgb = '0;
    if (w_synced && r_attr_s1.vis && r_attr_s1.in_grid) begin
      if (r_attr_s1.border)    w_rgb = GRID_RGB;
      else if (cbuf.cell_data) w_rgb = ALIVE_RGB;
      else                     w_rgb = DEAD_RGB;
    end
  end

  assign cbuf.cell_rd_en       = r_cell_rd_en;
  assign cbuf.cell_addr        = r_cell_addr;
  assign {vga_r, vga_g, vga_b} = r_rgb;
  assign vga_hs                = r_hs_pipe[STAGES-1];
  assign vga_vs                = r_vs_pipe[STAGES-1];
  assign frame_done            = r_frame_done;
endmodule

// File: tb/tb_cell_grid_renderer.sv
// Scoreboarded bench: reduced geometry, two renderers (grid lines on/off) sharing one cell memory.
module tb_cell_grid_renderer;
  import vga_pkg::*;

  localparam int COLS = 4, ROWS = 3, CW = 4, CH = 3;
  localparam int GW = COLS * CW, GH = ROWS * CH;
  localparam int H_VIS = 18, H_TOT = 24, V_VIS = 11, V_TOT = 14;
  localparam int HS_BEG = 20, HS_END = 22, VS_LINE = 12;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int PAT_AT = V_VIS * H_TOT + 2;
  localparam int RST_AT = 5 * H_TOT + 9;
  localparam int N_CYC = 8 * FRAME;

  typedef struct packed { rgb12_t rgb_g; rgb12_t rgb_n; logic hs; logic vs; } pix_exp_t;
  typedef struct packed { logic chk; logic rd_en; cell_addr_t addr; logic fd; } s0_exp_t;
  localparam pix_exp_t RST_PIX = '{rgb_g: 12'h000, rgb_n: 12'h000, hs: 1'b1, vs: 1'b1};
  localparam s0_exp_t  RST_S0  = '{chk: 1'b1, rd_en: 1'b0, addr: 9'd0, fd: 1'b0};

  logic pixel_clock = 1'b0;
  logic rst_n = 1'b0;
  logic hblank_n = 1'b0, vblank_n = 1'b0, hsync_n = 1'b1, vsync_n = 1'b1;
  logic [3:0] r_g, g_g, b_g, r_n, g_n, b_n;
  logic hs_g, vs_g, hs_n, vs_n, fd_g, fd_n;
  logic mem [0:511];
  logic rd_g = 1'b0, rd_n = 1'b0;

  pix_exp_t pq[$];
  s0_exp_t  aq[$];
  int checks = 0, errors = 0;
  bit synced = 1'b0, prev_vb = 1'b0;

  always #5 pixel_clock = ~pixel_clock;

  cell_grid_renderer_if cb_g ();
  cell_grid_renderer_if cb_n ();

  cell_grid_renderer #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .CH(CH), .GRID_EN(1'b1)) u_dut_g (
    .pixel_clock(pixel_clock), .rst_n(rst_n), .hblank_n(hblank_n), .vblank_n(vblank_n),
    .hsync_n_in(hsync_n), .vsync_n_in(vsync_n), .cbuf(cb_g),
    .vga_r(r_g), .vga_g(g_g), .vga_b(b_g), .vga_hs(hs_g), .vga_vs(vs_g), .frame_done(fd_g));

  cell_grid_renderer #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .CH(CH), .GRID_EN(1'b0)) u_dut_n (
    .pixel_clock(pixel_clock), .rst_n(rst_n), .hblank_n(hblank_n), .vblank_n(vblank_n),
    .hsync_n_in(hsync_n), .vsync_n_in(vsync_n), .cbuf(cb_n),
    .vga_r(r_n), .vga_g(g_n), .vga_b(b_n), .vga_hs(hs_n), .vga_vs(vs_n), .frame_done(fd_n));

  // Synchronous-read cell buffers, one cycle of latency.
  always @(posedge pixel_clock) begin
    if (cb_g.cell_rd_en) rd_g <= mem[cb_g.cell_addr];
    if (cb_n.cell_rd_en) rd_n <= mem[cb_n.cell_addr];
  end
  assign cb_g.cell_data = rd_g;
  assign cb_n.cell_data = rd_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rgb12_t ref_rgb(input int x, input int y, input bit gen);
    if (x >= GW || y >= GH) return 12'h000;
    if (gen && ((x % CW) == 0 || (y % CH) == 0)) return 12'h444;
    return mem[(y / CH) * COLS + x / CW] ? 12'hFFF : 12'h000;
  endfunction

  task automatic load_pattern(input int n);
    for (int i = 0; i < 512; i++) mem[i] = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (n <= 1)      mem[r * COLS + c] = (r == 0 && c == 0);
        else if (n <= 3) mem[r * COLS + c] = ((r + c) % 2) == 1;
        else             mem[r * COLS + c] = 1'($urandom_range(0, 1));
  endtask

  // One pixel slot: drive timing for frame offset c, push the expected responses.
  task automatic slot(input int c, input bit mode_b, input bit rst_v);
    int h, v;
    bit hb, vb, blank, ing;
    pix_exp_t pe;
    s0_exp_t  ae;
    @(posedge pixel_clock); #1;
    h = c % H_TOT;
    v = c / H_TOT;
    hb = (h < H_VIS);
    // mode_b drops vblank together with the hblank fall of the last visible line
    vb = mode_b ? (c < V_VIS * H_TOT - (H_TOT - H_VIS)) : (c < V_VIS * H_TOT);
    if (!rst_v && rst_n) begin
      rst_n = 1'b0;
      foreach (pq[i]) pq[i] = RST_PIX;
      foreach (aq[i]) aq[i] = RST_S0;
      synced = 1'b0;
      prev_vb = 1'b0;
    end else begin
      rst_n = rst_v;
    end
    hblank_n = hb;
    vblank_n = vb;
    hsync_n  = !(h >= HS_BEG && h < HS_END);
    vsync_n  = !(v == VS_LINE);
    blank = hb && vb;
    ing = (h < GW) && (v < GH);
    if (!rst_n) begin
      pe = RST_PIX;
      ae = RST_S0;
    end else begin
      pe.hs    = hsync_n;
      pe.vs    = vsync_n;
      pe.rgb_g = (blank && synced) ? ref_rgb(h, v, 1'b1) : 12'h000;
      pe.rgb_n = (blank && synced) ? ref_rgb(h, v, 1'b0) : 12'h000;
      ae.chk   = synced;
      ae.rd_en = blank && ing;
      ae.addr  = ing ? cell_addr_t'((v / CH) * COLS + h / CW) : '0;
      ae.fd    = synced && prev_vb && !vb;
      if (!vb) synced = 1'b1;
      prev_vb = vb;
    end
    pq.push_back(pe);
    aq.push_back(ae);
  endtask

  initial begin : driver
    int c, f, fidx;
    bit rv;
    fidx = 0;
    load_pattern(fidx);
    c = 95;
    f = 0;
    for (int n = 0; n < N_CYC; n++) begin
      rv = !(n < 5 || (f == 4 && c >= RST_AT && c < RST_AT + 3));
      slot(c, f[0], rv);
      if (c == PAT_AT) begin
        fidx++;
        load_pattern(fidx);
      end
      c++;
      if (c == FRAME) begin
        c = 0;
        f++;
      end
    end
    repeat (2) @(negedge pixel_clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : monitor
    pix_exp_t pe;
    s0_exp_t  ae;
    forever begin
      @(negedge pixel_clock);
      while (pq.size() > 3) begin
        pe = pq.pop_front();
        check("rgb_grid_on", {r_g, g_g, b_g}, pe.rgb_g);
        check("rgb_grid_off", {r_n, g_n, b_n}, pe.rgb_n);
        check("vga_hs", hs_g, pe.hs);
        check("vga_vs", vs_g, pe.vs);
        check("vga_hs_off", hs_n, pe.hs);
        check("vga_vs_off", vs_n, pe.vs);
      end
      while (aq.size() > 1) begin
        ae = aq.pop_front();
        check("frame_done", fd_g, ae.fd);
        check("frame_done_off", fd_n, ae.fd);
        if (ae.chk) begin
          check("cell_rd_en", cb_g.cell_rd_en, ae.rd_en);
          check("cell_rd_en_off", cb_n.cell_rd_en, ae.rd_en);
          if (ae.rd_en) begin
            check("cell_addr", cb_g.cell_addr, ae.addr);
            check("cell_addr_off", cb_n.cell_addr, ae.addr);
          end
        end
      end
    end
  end
endmodule
